// File: rtl/jtag_scan_master.sv
// JTAG scan master: walks a target TAP through one IR scan and then one DR scan for each accepted request.
// A legal request completes W+N+11 edges after acceptance; an illegal one completes on the next edge with an error.
module jtag_scan_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        startValid,
  output logic        startReady,
  input  logic [4:0]  instruction,
  input  logic [2:0]  instructionWidth,
  input  logic [31:0] testVector,
  input  logic [5:0]  testVectorWidth,
  output logic        jtagTms,
  output logic        jtagTdi,
  input  logic        jtagTdo,
  output logic        doneValid,
  output logic        doneError,
  output logic [31:0] capturedVector,
  output logic        busy
);

  typedef enum logic [3:0] {
    jtagResetState, jtagIdleState,
    jtagIrScanState, jtagCaptureIrState, jtagShiftIrState, jtagExit1IrState,
    jtagPauseIrState, jtagExit2IrState, jtagUpdateIrState,
    jtagDrScanState, jtagCaptureDrState, jtagShiftDrState, jtagExit1DrState,
    jtagPauseDrState, jtagExit2DrState, jtagUpdateDrState
  } tap_state_t;

  typedef enum logic {PHASE_IR, PHASE_DR} phase_t;

  tap_state_t  tapState;
  tap_state_t  tap_next;
  phase_t      phase;
  logic [2:0]  initCount;
  logic [4:0]  bit_count;
  logic [4:0]  ir_shift;
  logic [31:0] dr_shift;
  logic [4:0]  dr_last;
  logic [4:0]  cap_index;
  logic        init_done;
  logic        req_legal;
  logic        accept;

  assign init_done  = (initCount == 3'd5);
  assign req_legal  = (instructionWidth >= 3'd3) && (instructionWidth <= 3'd5) &&
                      ((testVectorWidth == 6'd8)  || (testVectorWidth == 6'd16) ||
                       (testVectorWidth == 6'd24) || (testVectorWidth == 6'd32));
  assign startReady = (tapState == jtagIdleState) && init_done && (phase == PHASE_IR);
  assign busy       = !startReady;
  assign accept     = startValid && startReady;
  assign jtagTdi    = (tapState == jtagShiftIrState) ? ir_shift[0] :
                      (tapState == jtagShiftDrState) ? dr_shift[0] : 1'b0;

  // TMS is chosen from the mirrored state; the target follows the same path on the same edge.
  always_comb begin
    jtagTms  = 1'b0;
    tap_next = tapState;
    case (tapState)
      jtagResetState:   jtagTms = !init_done;
      jtagIdleState:    jtagTms = (phase == PHASE_DR) || (startValid && req_legal && init_done);
      jtagDrScanState:  jtagTms = (phase == PHASE_IR);
      jtagShiftIrState,
      jtagShiftDrState: jtagTms = (bit_count == 5'd0);
      jtagExit1IrState, jtagPauseIrState, jtagExit2IrState,
      jtagExit1DrState, jtagPauseDrState, jtagExit2DrState: jtagTms = 1'b1;
      default:          jtagTms = 1'b0;
    endcase

    case (tapState)
      jtagResetState:     tap_next = jtagTms ? jtagResetState   : jtagIdleState;
      jtagIdleState:      tap_next = jtagTms ? jtagDrScanState  : jtagIdleState;
      jtagIrScanState:    tap_next = jtagTms ? jtagResetState   : jtagCaptureIrState;
      jtagCaptureIrState: tap_next = jtagTms ? jtagExit1IrState : jtagShiftIrState;
      jtagShiftIrState:   tap_next = jtagTms ? jtagExit1IrState : jtagShiftIrState;
      jtagExit1IrState:   tap_next = jtagTms ? jtagUpdateIrState : jtagPauseIrState;
      jtagPauseIrState:   tap_next = jtagTms ? jtagExit2IrState : jtagPauseIrState;
      jtagExit2IrState:   tap_next = jtagTms ? jtagUpdateIrState : jtagShiftIrState;
      jtagUpdateIrState:  tap_next = jtagTms ? jtagDrScanState  : jtagIdleState;
      jtagDrScanState:    tap_next = jtagTms ? jtagIrScanState  : jtagCaptureDrState;
      jtagCaptureDrState: tap_next = jtagTms ? jtagExit1DrState : jtagShiftDrState;
      jtagShiftDrState:   tap_next = jtagTms ? jtagExit1DrState : jtagShiftDrState;
      jtagExit1DrState:   tap_next = jtagTms ? jtagUpdateDrState : jtagPauseDrState;
      jtagPauseDrState:   tap_next = jtagTms ? jtagExit2DrState : jtagPauseDrState;
      jtagExit2DrState:   tap_next = jtagTms ? jtagUpdateDrState : jtagShiftDrState;
      jtagUpdateDrState:  tap_next = jtagTms ? jtagDrScanState  : jtagIdleState;
      default:            tap_next = jtagResetState;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tapState       <= jtagResetState;
      initCount      <= 3'd0;
      phase          <= PHASE_IR;
      bit_count      <= 5'd0;
      ir_shift       <= 5'd0;
      dr_shift       <= 32'd0;
      dr_last        <= 5'd0;
      cap_index      <= 5'd0;
      capturedVector <= 32'd0;
      doneValid      <= 1'b0;
      doneError      <= 1'b0;
    end else begin
      tapState  <= tap_next;
      doneValid <= 1'b0;
      doneError <= 1'b0;

      if ((tapState == jtagResetState) && !init_done)
        initCount <= initCount + 3'd1;

      if (accept) begin
        ir_shift  <= instruction;
        dr_shift  <= testVector;
        dr_last   <= 5'(testVectorWidth - 6'd1);
        bit_count <= {2'b00, instructionWidth} - 5'd1;
        if (req_legal) begin
          capturedVector <= 32'd0;
          cap_index      <= 5'd0;
        end else begin
          doneValid <= 1'b1;
          doneError <= 1'b1;
        end
      end

      // acceptance only happens in Idle, so it never collides with these updates
      case (tapState)
        jtagShiftIrState: begin
          ir_shift  <= ir_shift >> 1;
          bit_count <= bit_count - 5'd1;
        end
        jtagShiftDrState: begin
          dr_shift                  <= dr_shift >> 1;
          bit_count                 <= bit_count - 5'd1;
          capturedVector[cap_index] <= jtagTdo;
          cap_index                 <= cap_index + 5'd1;
        end
        jtagUpdateIrState: begin
          phase     <= PHASE_DR;
          bit_count <= dr_last;
        end
        jtagUpdateDrState: begin
          phase     <= PHASE_IR;
          doneValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
